// File: rtl/fact_seq_if.sv
// ============================================================================
// Module   : fact_seq_if
// Brief    : Request/result and counter-control bundle for fact_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fact_seq_if #(
  parameter int SIZE = 8,
  parameter int PW   = 32
);
  logic            start;
  logic [SIZE-1:0] n;
  logic            busy;
  logic            done;
  logic [PW-1:0]   result;
  logic            ovf;
  logic            cnt_en;
  logic            cnt_load;
  logic [SIZE-1:0] cnt_d;
  logic [SIZE-1:0] cnt_q;

  modport master (
    output start, n, cnt_q,
    input  busy, done, result, ovf, cnt_en, cnt_load, cnt_d
  );

  modport slave (
    input  start, n, cnt_q,
    output busy, done, result, ovf, cnt_en, cnt_load, cnt_d
  );
endinterface

`default_nettype wire

// File: rtl/fact_seq.sv
// ============================================================================
// Module   : fact_seq
// Brief    : Iterative n! sequencer driving an external loadable up-counter.
//            Define FACT_SAT_EN to saturate result to all-ones on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fact_seq #(
  parameter int SIZE = 8,
  parameter int PW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fact_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] c_one = {{(SIZE-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SIZE-1:0]     r_n_eff;
  logic [PW-1:0]       r_acc;
  logic                r_ovf_run;
  logic [PW-1:0]       r_result;
  logic                r_ovf;
  logic                r_done;

  logic                w_cnt_en;
  logic                w_cnt_load;
  logic [PW+SIZE-1:0]  w_prod;
  logic                w_prod_ovf;
  logic                w_ovf_final;
  logic                w_last;
  logic [PW-1:0]       w_result_final;

  assign w_prod      = {{SIZE{1'b0}}, r_acc} * {{PW{1'b0}}, bus.cnt_q};
  assign w_prod_ovf  = |w_prod[PW+SIZE-1:PW];
  assign w_ovf_final = r_ovf_run | w_prod_ovf;
  assign w_last      = (bus.cnt_q == r_n_eff);

`ifdef FACT_SAT_EN
  assign w_result_final = w_ovf_final ? {PW{1'b1}} : w_prod[PW-1:0];
`else
  assign w_result_final = w_prod[PW-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    w_cnt_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cnt_en    = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_cnt_en    = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_eff   <= '0;
      r_acc     <= {{(PW-1){1'b0}}, 1'b1};
      r_ovf_run <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n_eff   <= (bus.n == '0) ? c_one : bus.n;
            r_acc     <= {{(PW-1){1'b0}}, 1'b1};
            r_ovf_run <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc     <= w_prod[PW-1:0];
          r_ovf_run <= w_ovf_final;
          // Final multiply is folded into result/ovf on the exit edge.
          if (w_last) begin
            r_result <= w_result_final;
            r_ovf    <= w_ovf_final;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counter controls are held inactive for the whole reset window.
  assign bus.cnt_en   = w_cnt_en & rst_n;
  assign bus.cnt_load = w_cnt_load & rst_n;
  assign bus.cnt_d    = c_one;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fact_seq.sv
// ============================================================================
// Module   : tb_fact_seq
// Brief    : Self-checking bench for fact_seq with a behavioural counter and
//            an arithmetic factorial reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fact_seq;

  localparam int SIZE = 8;
  localparam int PW   = 32;

  logic clk;
  logic rst_n;
  logic [SIZE-1:0] r_cnt;

  int n_tests;
  int n_fail;

  fact_seq_if #(.SIZE(SIZE), .PW(PW)) bus ();

  fact_seq #(.SIZE(SIZE), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loadable up-counter the sequencer drives; deliberately unreset.
  initial r_cnt = '0;
  always @(posedge clk) begin
    if (bus.cnt_en) r_cnt <= bus.cnt_load ? bus.cnt_d : r_cnt + 1'b1;
  end
  assign bus.cnt_q = r_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // n! from plain arithmetic: low PW bits of the true product, overflow when
  // the true product no longer fits in PW bits.
  task automatic model(input int nv, output logic [63:0] res, output logic ov);
    longint unsigned wrapped;
    longint unsigned exact;
    longint unsigned mask;
    int neff;
    mask    = (64'd1 << PW) - 64'd1;
    wrapped = 1;
    exact   = 1;
    ov      = 1'b0;
    neff    = (nv == 0) ? 1 : nv;
    for (int k = 1; k <= neff; k++) begin
      wrapped = (wrapped * longint'(k)) & mask;
      if (!ov) begin
        exact = exact * longint'(k);
        if (exact > mask) ov = 1'b1;
      end
    end
`ifdef FACT_SAT_EN
    res = ov ? mask : wrapped;
`else
    res = wrapped;
`endif
  endtask

  // One full run from the accept cycle T to the first idle cycle after DONE.
  task automatic do_run(input int nv, input bit pulse_mid, input bit start_in_done);
    int neff;
    logic [63:0] exp_res;
    logic exp_ovf;
    neff = (nv == 0) ? 1 : nv;
    model(nv, exp_res, exp_ovf);

    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv[SIZE-1:0];
    #1;
    chk("accept_load", bus.cnt_load, 1);
    chk("accept_en",   bus.cnt_en,   1);
    chk("accept_busy", bus.busy,     0);

    for (int cyc = 1; cyc <= neff + 1; cyc++) begin
      @(negedge clk);
      bus.start = (pulse_mid && cyc == 3) || (start_in_done && cyc == neff + 1);
      bus.n     = SIZE'($urandom);
      #1;
      chk("busy",     bus.busy,     1);
      chk("done",     bus.done,     (cyc == neff + 1) ? 1 : 0);
      chk("cnt_load", bus.cnt_load, 0);
      chk("cnt_en",   bus.cnt_en,   (cyc < neff) ? 1 : 0);
      if (cyc <= neff) chk("cnt_q", bus.cnt_q, cyc);
      if (cyc == neff + 1) begin
        chk("result_at_done", bus.result, exp_res);
        chk("ovf_at_done",    bus.ovf,    exp_ovf);
      end
    end

    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("idle_busy",   bus.busy,   0);
    chk("idle_done",   bus.done,   0);
    chk("held_result", bus.result, exp_res);
    chk("held_ovf",    bus.ovf,    exp_ovf);
  endtask

  initial begin
    int nv;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.n     = 8'd3;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    chk("rst_result",   bus.result,   0);
    chk("rst_ovf",      bus.ovf,      0);
    chk("rst_cnt_en",   bus.cnt_en,   0);
    chk("rst_cnt_load", bus.cnt_load, 0);
    chk("cnt_d",        bus.cnt_d,    1);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_run(5, 1'b0, 1'b0);
    chk("n5_value", bus.result, 120);
    do_run(0, 1'b0, 1'b0);
    chk("n0_value", bus.result, 1);
    do_run(1, 1'b0, 1'b0);
    do_run(12, 1'b0, 1'b0);
    chk("n12_value", bus.result, 479001600);
    do_run(13, 1'b0, 1'b0);
`ifdef FACT_SAT_EN
    chk("n13_value", bus.result, 32'hFFFFFFFF);
`else
    chk("n13_value", bus.result, 1932053504);
`endif
    chk("n13_ovf", bus.ovf, 1);
    do_run(5, 1'b1, 1'b1);
    chk("n5_restart_value", bus.result, 120);

    // Mid-run reset at T+3 of an n=6 run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("abort_busy",     bus.busy,     0);
    chk("abort_done",     bus.done,     0);
    chk("abort_result",   bus.result,   0);
    chk("abort_ovf",      bus.ovf,      0);
    chk("abort_cnt_en",   bus.cnt_en,   0);
    chk("abort_cnt_load", bus.cnt_load, 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("post_abort_busy", bus.busy, 0);
    do_run(4, 1'b0, 1'b0);
    chk("n4_value", bus.result, 24);

    do_run(255, 1'b0, 1'b0);
    chk("n255_ovf", bus.ovf, 1);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) nv = int'($urandom_range(13, 60));
      else                           nv = int'($urandom_range(0, 12));
      do_run(nv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
